// File: rtl/dc_line_ctrl.sv
// Data-cache miss sequencer: optional 4-beat victim writeback, 4-beat refill, line write + tag update.
// Latency with mem_ack high: 6 cycles clean, 12 dirty to dc_stall_fin; each mem_ack=0 cycle stalls one cycle.
module dc_line_ctrl #(
  parameter int DWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [27:0]       miss_adr,
  input  logic              miss_dirty,
  input  logic [27:0]       victim_adr,
  output logic              busy,
  output logic              dc_stall_fin,
  output logic              tag_wen,
  output logic [DWIDTH-3:0] ram_radr_all,
  output logic              ram_ren_all,
  input  logic [127:0]      ram_rdata_all,
  output logic [DWIDTH-3:0] ram_wadr_all,
  output logic [127:0]      ram_wdata_all,
  output logic              ram_wen_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [29:0]       mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int IW = DWIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_RD,
    S_WB_LAT,
    S_WB_BEAT,
    S_RF_BEAT,
    S_RF_WR,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] buf_q, buf_d;
  logic [27:0]  miss_adr_q, miss_adr_d;
  logic [27:0]  vic_adr_q, vic_adr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      buf_q      <= 128'd0;
      miss_adr_q <= 28'd0;
      vic_adr_q  <= 28'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      miss_adr_q <= miss_adr_d;
      vic_adr_q  <= vic_adr_d;
    end
  end

  // Outputs are decoded from state only, so every output is 0 while idle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    miss_adr_d    = miss_adr_q;
    vic_adr_d     = vic_adr_q;
    busy          = 1'b1;
    dc_stall_fin  = 1'b0;
    tag_wen       = 1'b0;
    ram_radr_all  = '0;
    ram_ren_all   = 1'b0;
    ram_wadr_all  = '0;
    ram_wdata_all = 128'd0;
    ram_wen_all   = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_adr       = 30'd0;
    mem_wdata     = 32'd0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (miss_req) begin
          miss_adr_d = miss_adr;
          vic_adr_d  = victim_adr;
          cnt_d      = 2'd0;
          state_d    = miss_dirty ? S_WB_RD : S_RF_BEAT;
        end
      end
      S_WB_RD: begin
        ram_ren_all  = 1'b1;
        ram_radr_all = vic_adr_q[IW-1:0];
        state_d      = S_WB_LAT;
      end
      S_WB_LAT: begin
        buf_d   = ram_rdata_all;
        cnt_d   = 2'd0;
        state_d = S_WB_BEAT;
      end
      S_WB_BEAT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = {vic_adr_q, cnt_q};
        mem_wdata = buf_q[{cnt_q, 5'b0} +: 32];
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RF_BEAT;
        end
      end
      S_RF_BEAT: begin
        mem_req = 1'b1;
        mem_adr = {miss_adr_q, cnt_q};
        if (mem_ack) begin
          buf_d[{cnt_q, 5'b0} +: 32] = mem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_RF_WR;
        end
      end
      S_RF_WR: begin
        ram_wen_all   = 1'b1;
        ram_wadr_all  = miss_adr_q[IW-1:0];
        ram_wdata_all = buf_q;
        tag_wen       = 1'b1;
        state_d       = S_DONE;
      end
      S_DONE: begin
        dc_stall_fin = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dc_line_ctrl.sv
// Bench for dc_line_ctrl: bench-owned data RAM and external memory models, transaction-level expectations.
module tb_dc_line_ctrl;
  localparam int DW = 14;
  localparam int IW = DW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_req;
  logic [27:0]   miss_adr;
  logic          miss_dirty;
  logic [27:0]   victim_adr;
  logic          busy;
  logic          dc_stall_fin;
  logic          tag_wen;
  logic [IW-1:0] ram_radr_all;
  logic          ram_ren_all;
  logic [127:0]  ram_rdata_all;
  logic [IW-1:0] ram_wadr_all;
  logic [127:0]  ram_wdata_all;
  logic          ram_wen_all;
  logic          mem_req;
  logic          mem_we;
  logic [29:0]   mem_adr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  dc_line_ctrl #(.DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_adr(miss_adr),
    .miss_dirty(miss_dirty), .victim_adr(victim_adr), .busy(busy),
    .dc_stall_fin(dc_stall_fin), .tag_wen(tag_wen), .ram_radr_all(ram_radr_all),
    .ram_ren_all(ram_ren_all), .ram_rdata_all(ram_rdata_all), .ram_wadr_all(ram_wadr_all),
    .ram_wdata_all(ram_wdata_all), .ram_wen_all(ram_wen_all), .mem_req(mem_req),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] dram [0:(1<<IW)-1];
  logic [31:0]  emem [logic [29:0]];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] emem_rd(input logic [29:0] a);
    if (emem.exists(a)) return emem[a];
    return {a, 2'b11} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic any_out();
    return |{busy, dc_stall_fin, tag_wen, ram_radr_all, ram_ren_all, ram_wadr_all,
             ram_wdata_all, ram_wen_all, mem_req, mem_we, mem_adr, mem_wdata};
  endfunction

  task automatic idle_chk(input string tag);
    @(negedge clk);
    ram_rdata_all = {$urandom, $urandom, $urandom, $urandom};
    chk(tag, any_out(), 0);
  endtask

  // ack_mode: 0 always ack, 1 random acks (plus stray acks while idle on the bus),
  // 2 hold ack low for 3 cycles on refill beat 2. abort_at>0 asserts rst in that cycle.
  task automatic run_miss(input logic [27:0] madr, input logic dirty, input logic [27:0] vadr,
                          input int ack_mode, input int abort_at);
    logic [IW-1:0] midx, vidx, pend_idx;
    logic [127:0]  vline, exp_line, line_before;
    logic [29:0]   exp_adr [$];
    logic [31:0]   exp_dat [$];
    logic          exp_we  [$];
    logic          pend_rd, a, prev_wait, prev_we;
    logic [29:0]   prev_adr;
    logic [31:0]   prev_wd;
    int waits, nbeats, nwen, nren, fin_cyc, busy_low, tag_bad, hold_bad, stall, bad;

    midx = madr[IW-1:0];
    vidx = vadr[IW-1:0];
    vline = dram[vidx];
    line_before = dram[midx];
    exp_line = '0;
    if (dirty) begin
      for (int n = 0; n < 4; n++) begin
        exp_adr.push_back({vadr, 2'(n)});
        exp_dat.push_back(vline[32*n +: 32]);
        exp_we.push_back(1'b1);
      end
    end
    for (int n = 0; n < 4; n++) begin
      exp_adr.push_back({madr, 2'(n)});
      exp_dat.push_back(32'd0);
      exp_we.push_back(1'b0);
      exp_line[32*n +: 32] = (dirty && vadr == madr) ? vline[32*n +: 32] : emem_rd({madr, 2'(n)});
    end

    waits = 0; nbeats = 0; nwen = 0; nren = 0; fin_cyc = -1; busy_low = 0;
    tag_bad = 0; hold_bad = 0; stall = 0; pend_rd = 1'b0; pend_idx = '0;
    prev_wait = 1'b0; prev_we = 1'b0; prev_adr = '0; prev_wd = '0;

    miss_req = 1'b1; miss_adr = madr; miss_dirty = dirty; victim_adr = vadr; mem_ack = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        miss_adr = 28'($urandom); victim_adr = 28'($urandom); miss_dirty = 1'($urandom);
      end
      ram_rdata_all = pend_rd ? dram[pend_idx] : {$urandom, $urandom, $urandom, $urandom};
      pend_rd = ram_ren_all;
      pend_idx = ram_radr_all;
      if (ram_ren_all) begin
        nren++;
        chk("ren_idx", ram_radr_all, vidx);
      end
      if (!busy) busy_low++;
      if (tag_wen != ram_wen_all) tag_bad++;
      if (ram_wen_all) begin
        nwen++;
        chk("wr_idx", ram_wadr_all, midx);
        chk("wr_line", ram_wdata_all, exp_line);
        dram[ram_wadr_all] = ram_wdata_all;
      end
      if (prev_wait && !(mem_req && mem_adr == prev_adr && mem_we == prev_we &&
                         (!prev_we || mem_wdata == prev_wd)))
        hold_bad++;
      if (mem_req) begin
        case (ack_mode)
          0: a = 1'b1;
          1: a = ($urandom_range(0, 3) != 0);
          default: a = !(nbeats == (dirty ? 6 : 2) && stall < 3);
        endcase
        if (!a) begin
          waits++;
          stall = (nbeats == (dirty ? 6 : 2)) ? stall + 1 : stall;
        end
        mem_ack = a;
        mem_rdata = (a && !mem_we) ? emem_rd(mem_adr) : $urandom;
        if (a) begin
          if (nbeats < exp_adr.size()) begin
            chk("beat_adr", mem_adr, exp_adr[nbeats]);
            chk("beat_we", mem_we, exp_we[nbeats]);
            if (exp_we[nbeats]) chk("beat_dat", mem_wdata, exp_dat[nbeats]);
          end
          if (mem_we) emem[mem_adr] = mem_wdata;
          nbeats++;
        end
        prev_wait = !a; prev_adr = mem_adr; prev_we = mem_we; prev_wd = mem_wdata;
      end else begin
        mem_ack = (ack_mode == 1) ? 1'($urandom) : 1'b0;
        mem_rdata = $urandom;
        prev_wait = 1'b0;
      end
      if (abort_at > 0 && cyc == abort_at) begin
        chk("abort_beat", mem_adr, {vadr, 2'd1});
        rst = 1'b1;
        break;
      end
      if (dc_stall_fin) begin
        fin_cyc = cyc;
        miss_req = 1'b0;
        mem_ack = 1'b0;
        break;
      end
    end

    if (abort_at > 0) begin
      @(negedge clk);
      chk("rst_outs", any_out(), 0);
      rst = 1'b0; miss_req = 1'b0; mem_ack = 1'b0;
      bad = 0;
      repeat (8) begin
        @(negedge clk);
        if (ram_wen_all || tag_wen || dc_stall_fin || busy) bad++;
      end
      chk("rst_quiet", bad, 0);
      chk("rst_line", dram[midx], line_before);
    end else begin
      if (fin_cyc < 0) miss_req = 1'b0;
      chk("fin_lat", fin_cyc, (dirty ? 12 : 6) + waits);
      chk("beats", nbeats, exp_adr.size());
      chk("ram_wen_cnt", nwen, 1);
      chk("ren_cnt", nren, dirty ? 1 : 0);
      chk("busy_low", busy_low, 0);
      chk("tag_sync", tag_bad, 0);
      chk("hold", hold_bad, 0);
      if (ack_mode == 2) chk("wait_cnt", waits, 3);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line_a;
    logic [27:0]  ma, va;
    for (int i = 0; i < (1 << IW); i++)
      dram[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1; miss_req = 1'b0; miss_adr = '0; miss_dirty = 1'b0; victim_adr = '0;
    ram_rdata_all = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", any_out(), 0);
    rst = 1'b0;
    idle_chk("idle_after_reset");

    // stray ack in idle
    mem_ack = 1'b1;
    idle_chk("idle_stray_ack");
    mem_ack = 1'b0;
    idle_chk("idle_stray_ack2");

    // clean directed miss
    for (int n = 0; n < 4; n++) emem[{28'h0000123, 2'(n)}] = 32'h1111_1111 * (n + 1);
    run_miss(28'h0000123, 1'b0, 28'h0000999, 0, 0);
    chk("clean_line", dram[12'h123], 128'h44444444_33333333_22222222_11111111);
    idle_chk("idle_after_clean");

    // dirty directed miss
    dram[12'h040] = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_0000;
    run_miss(28'h0000777, 1'b1, 28'h0000040, 0, 0);
    chk("wb_word0", emem[30'h100], 32'h7777_0000);
    chk("wb_word3", emem[30'h103], 32'hDDDD_CCCC);
    idle_chk("idle_after_dirty");

    // wait states on refill beat 2
    run_miss(28'h0000321, 1'b0, 28'h0000000, 2, 0);
    idle_chk("idle_after_wait");

    // reset mid writeback, then fresh miss
    run_miss(28'h0000456, 1'b1, 28'h0000089, 0, 4);
    run_miss(28'h0000456, 1'b1, 28'h0000089, 0, 0);
    idle_chk("idle_after_rst");

    // back-to-back
    run_miss(28'h0000A10, 1'b0, 28'h0000000, 0, 0);
    line_a = dram[12'hA10];
    idle_chk("b2b_idle");
    run_miss(28'h0000B20, 1'b1, 28'h0000C30, 0, 0);
    chk("b2b_first", dram[12'hA10], line_a);
    idle_chk("idle_after_b2b");

    // index all-ones, and victim equal to miss line
    run_miss(28'hABCDFFF, 1'b1, 28'h1234FFF, 1, 0);
    chk("edge_line_fff_idx", dram[12'hFFF] !== 128'hx, 1);
    idle_chk("idle_after_fff");
    run_miss(28'h0000E55, 1'b1, 28'h0000E55, 1, 0);
    idle_chk("idle_after_same");

    // randomized misses
    for (int t = 0; t < 20; t++) begin
      ma = 28'($urandom);
      if ($urandom_range(0, 4) == 0) ma[IW-1:0] = '1;
      va = ($urandom_range(0, 5) == 0) ? ma : 28'($urandom);
      run_miss(ma, 1'($urandom), va, $urandom_range(0, 1), 0);
      idle_chk("idle_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
